// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: state encoding, lane geometry and lane bit-position helper.
package packer_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned WORD_W    = LANES * LANE_W;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned BIT_IDX_W = 5;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Lowest bit of lane k inside the assembled word for the chosen byte order.
    function automatic logic [BIT_IDX_W-1:0] lane_lsb(input int unsigned k, input bit le);
        int unsigned pos;
        pos = le ? (k * LANE_W) : ((LANES - 1 - k) * LANE_W);
        return BIT_IDX_W'(pos);
    endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte-stream handshake plus FIFO push bus for the byte packer.
interface byte_packer_if;
    import packer_pkg::*;

    logic                byte_valid;
    logic [LANE_W-1:0]   byte_in;
    logic                byte_last;
    logic                byte_ready;
    logic                fifo_full;
    logic                push;
    logic [WORD_W-1:0]   word_out;
    logic [CNT_W-1:0]    word_bytes;

    // Upstream byte source together with the downstream FIFO.
    modport master (
        output byte_valid, byte_in, byte_last, fifo_full,
        input  byte_ready, push, word_out, word_bytes
    );

    // The packer itself.
    modport slave (
        input  byte_valid, byte_in, byte_last, fifo_full,
        output byte_ready, push, word_out, word_bytes
    );

endinterface

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit words and pushes them into a downstream FIFO.
// Optional end-of-packet flush with padding is enabled by defining BYTE_PACKER_FLUSH_EN.
module byte_packer
    import packer_pkg::*;
#(
    parameter logic [LANE_W-1:0] PAD_BYTE      = 8'h00,
    parameter bit                LITTLE_ENDIAN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    byte_packer_if.slave  bus
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic [CNT_W-1:0]    bytes_q, bytes_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            word_q  <= '0;
            bytes_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            bytes_q <= bytes_d;
        end
    end

    // Next-state, lane write decode and word completion.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        bytes_d = bytes_q;
        case (state_q)
            ST_FILL: begin
                if (bus.byte_valid) begin
                    for (int unsigned k = 0; k < LANES; k++) begin
                        if (IDX_W'(k) == idx_q) begin
                            word_d[lane_lsb(k, LITTLE_ENDIAN) +: LANE_W] = bus.byte_in;
                        end
`ifdef BYTE_PACKER_FLUSH_EN
                        else if (bus.byte_last && (IDX_W'(k) > idx_q)) begin
                            word_d[lane_lsb(k, LITTLE_ENDIAN) +: LANE_W] = PAD_BYTE;
                        end
`endif
                    end
                    if (idx_q == IDX_W'(LANES - 1)) begin
                        bytes_d = CNT_W'(LANES);
                        state_d = ST_HOLD;
                    end
`ifdef BYTE_PACKER_FLUSH_EN
                    else if (bus.byte_last) begin
                        bytes_d = CNT_W'(idx_q) + CNT_W'(1);
                        state_d = ST_HOLD;
                    end
`endif
                    else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // The push edge is the only place the lane index wraps.
                if (!bus.fifo_full) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                    word_d  = '0;
                    bytes_d = '0;
                end
            end
        endcase
    end

`ifndef BYTE_PACKER_FLUSH_EN
    localparam logic [LANE_W-1:0] unused_pad = PAD_BYTE;
    logic unused_last;
    assign unused_last = bus.byte_last;
`endif

    // Push is combinational so the FIFO captures word_out on the same edge.
    assign bus.push       = (state_q == ST_HOLD) && !bus.fifo_full && !reset;
    assign bus.byte_ready = (state_q == ST_FILL);
    assign bus.word_out   = word_q;
    assign bus.word_bytes = bytes_q;

endmodule
